pipe_gap_generator: RTL and testbench
=====================================

Name: pipe_gap_generator

Overview:
Downstream consumer of the 5-bit Fibonacci LFSR in the Flappy Bird game. It turns pseudo-random LFSR words into pipe obstacles and tracks up to PIPE_SLOTS pipes scrolling right-to-left, one step per frame. For each slot it gives the renderer and collision logic a valid flag, an x position and a gap y position. It also pulses once when a pipe passes the bird column, and the score counter consumes that pulse.

Parameters:
SCREEN_W, 640, x coordinate given to a newly spawned pipe
SPEED, 2, pixels subtracted from every valid pipe x per frame_tick
SPAWN_FRAMES, 80, frame_ticks between spawn attempts
GAP_MIN_Y, 80, gap y for LFSR value 0
GAP_STEP, 8, gap y increment per LFSR count
BIRD_X, 160, bird column used for score detection
PIPE_SLOTS, 4, number of pipe slots
X_W, 10, width of x fields
Y_W, 9, width of gap y fields
MAX_DELTA, 64, gap change limit (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  single-cycle frame advance strobe
game_run  in  1  level; high while the game is playing
game_clear  in  1  single-cycle; returns the block to IDLE
rnd_data  in  5  LFSR output, sampled only on a spawn
pipe_valid  out  PIPE_SLOTS  slot occupied
pipe_x  out  PIPE_SLOTS*X_W  packed x positions, slot 0 in the LSBs
pipe_gap_y  out  PIPE_SLOTS*Y_W  packed gap y positions, slot 0 in the LSBs
spawn_pulse  out  1  one cycle; a pipe was loaded
score_pulse  out  1  one cycle; at least one pipe crossed BIRD_X

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state goes to IDLE. pipe_valid, pipe_x, pipe_gap_y, spawn_pulse and score_pulse are all 0. spawn_cnt is 0.
- All outputs are registered. Every effect of a frame_tick is visible in the cycle after the tick.
- States:
  - IDLE: all slots are invalid. When game_run=1, move to RUN and load spawn_cnt=0, so the first spawn happens on the first frame_tick.
  - RUN: act on each frame_tick (see below). If game_run=0, move to FREEZE.
  - FREEZE: all registers hold; frame_tick is ignored. If game_run=1, return to RUN with no state lost.
  - Any state: game_clear=1 moves to IDLE and invalidates all slots. game_clear has priority over game_run. rst has priority over everything.
- RUN, per frame_tick, resolved in this order within the single update:
  1. Scroll: for each valid slot, x_new = x - SPEED. If x < SPEED, the slot retires (valid cleared, no underflow wrap).
  2. Score: score_pulse=1 if any valid slot has x >= BIRD_X and x_new < BIRD_X. Simultaneous crossings give a single pulse.
  3. Spawn: if spawn_cnt==0, take the lowest-index slot that is free after step 1. A slot retired in this same tick counts as free.
     - Load the slot: x=SCREEN_W, gap_y = GAP_MIN_Y + rnd_data*GAP_STEP, computed at Y_W width. Defaults cover 80..328; no overflow.
     - Assert spawn_pulse and reload spawn_cnt = SPAWN_FRAMES-1.
     - If no slot is free, spawn_cnt stays 0 and the spawn retries on the next tick. There is no pulse in that case.
  4. Otherwise, if spawn_cnt != 0, spawn_cnt decrements.
- rnd_data is sampled in the frame_tick cycle only. The value 0 is legal and maps to GAP_MIN_Y.
- A frame_tick that coincides with game_run falling is ignored; the FREEZE transition wins.

Optional Feature:
GAP_DIFF_LIMIT_EN
- Defined:
  - The block keeps last_gap_y (reset value GAP_MIN_Y).
  - A new gap_y is clamped to the range last_gap_y±MAX_DELTA, saturating at 0, before loading.
  - last_gap_y is updated on every spawn and reset to GAP_MIN_Y on game_clear.
- Undefined: raw mapping is used; no last_gap_y register exists.

Decomposition:
- Shared package pipe_pkg holds:
  - game geometry constants: SCREEN_W, BIRD_X, GAP_MIN_Y, GAP_STEP, X_W, Y_W;
  - the state enum: IDLE, RUN, FREEZE;
  - a pipe slot struct: valid, x, gap_y.
- One sub-module, pipe_slot, holds one slot's valid/x/gap_y registers. Its inputs are scroll, load and clear. Its outputs are retire and crossed (the BIRD_X crossing). It is instantiated PIPE_SLOTS times.
- The FSM, spawn counter and free-slot priority encoder stay in the top module.

Test Plan:
1. Reset, then game_run=1 and frame_tick with rnd_data=5 -> next cycle: spawn_pulse=1, slot0 valid, x=640, gap_y=120; spawn_pulse low the cycle after.
2. Spawn with rnd_data=31, then 240 frame_ticks -> slot0 x=160 at frame 240; score_pulse on the tick that takes x from 160 to 158; exactly one pulse.
3. SPAWN_FRAMES=1 with continuous ticks -> slots 0..3 fill on 4 consecutive ticks; 5th tick gives no spawn_pulse and spawn_cnt holds 0; when slot0 reaches x=0 and retires, slot0 is reloaded in that same tick.
4. game_run=0 for 50 cycles with frame_ticks -> all x and gap_y unchanged; game_run=1 resumes decrementing from the held values.
5. game_clear asserted mid-run alongside frame_tick -> next cycle: pipe_valid=0, no spawn_pulse or score_pulse; state IDLE.
6. With GAP_DIFF_LIMIT_EN: rnd 0 then rnd 31 -> gap_y values 80 then 144.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared geometry constants, FSM state type and pipe slot record for the
// pipe obstacle generator.
package pipe_pkg;

  localparam int SCREEN_W  = 640;
  localparam int BIRD_X    = 160;
  localparam int GAP_MIN_Y = 80;
  localparam int GAP_STEP  = 8;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int MAX_DELTA = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FREEZE
  } state_t;

  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] gap_y;
  } pipe_slot_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipe slot: holds valid/x/gap_y, scrolls left on request and reports
// when it is about to retire or cross the bird column.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int SPEED = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_scroll,
  input  logic           i_load,
  input  logic           i_clear,
  input  logic [Y_W-1:0] i_load_gap_y,
  output logic           o_valid,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_gap_y,
  output logic           o_retire,
  output logic           o_crossed
);

  pipe_slot_t     r_slot;
  logic [X_W-1:0] w_xNew;

  assign w_xNew    = r_slot.x - X_W'(SPEED);
  assign o_retire  = r_slot.valid && (r_slot.x < X_W'(SPEED));
  assign o_crossed = r_slot.valid && !o_retire &&
                     (r_slot.x >= X_W'(BIRD_X)) && (w_xNew < X_W'(BIRD_X));

  // A load wins over scrolling so a slot retiring this tick can be refilled.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_slot <= '0;
    end else if (i_load) begin
      r_slot.valid <= 1'b1;
      r_slot.x     <= X_W'(SCREEN_W);
      r_slot.gap_y <= i_load_gap_y;
    end else if (i_scroll && r_slot.valid) begin
      if (o_retire) begin
        r_slot.valid <= 1'b0;
        r_slot.x     <= '0;
      end else begin
        r_slot.x <= w_xNew;
      end
    end
  end

  assign o_valid = r_slot.valid;
  assign o_x     = r_slot.x;
  assign o_gap_y = r_slot.gap_y;

endmodule

// File: rtl/pipe_gap_generator.sv
// Turns LFSR words into scrolling pipe obstacles and pulses on bird-column
// crossings. Define GAP_DIFF_LIMIT_EN to clamp each new gap near the last one.
module pipe_gap_generator
  import pipe_pkg::*;
#(
  parameter int SPEED        = 2,
  parameter int SPAWN_FRAMES = 80,
  parameter int PIPE_SLOTS   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_frame_tick,
  input  logic                      i_game_run,
  input  logic                      i_game_clear,
  input  logic [4:0]                i_rnd_data,
  output logic [PIPE_SLOTS-1:0]     o_pipe_valid,
  output logic [PIPE_SLOTS*X_W-1:0] o_pipe_x,
  output logic [PIPE_SLOTS*Y_W-1:0] o_pipe_gap_y,
  output logic                      o_spawn_pulse,
  output logic                      o_score_pulse
);

  localparam int CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam int IDX_W = (PIPE_SLOTS > 1) ? $clog2(PIPE_SLOTS) : 1;

  state_t                r_state;
  state_t                w_nextState;
  logic [CNT_W-1:0]      r_spawnCnt;
  logic                  r_spawnPulse;
  logic                  r_scorePulse;

  logic                  w_advance;
  logic                  w_doSpawn;
  logic                  w_anyFree;
  logic [IDX_W-1:0]      w_freeIdx;
  logic [PIPE_SLOTS-1:0] w_free;
  logic [PIPE_SLOTS-1:0] w_retire;
  logic [PIPE_SLOTS-1:0] w_crossed;
  logic [Y_W-1:0]        w_rawGap;
  logic [Y_W-1:0]        w_gapY;

  // Ticks only count while running; a tick that coincides with run dropping is lost.
  assign w_advance = (r_state == RUN) && i_frame_tick && i_game_run && !i_game_clear;
  assign w_doSpawn = w_advance && (r_spawnCnt == '0) && w_anyFree;
  assign w_rawGap  = Y_W'(GAP_MIN_Y) + Y_W'(i_rnd_data) * Y_W'(GAP_STEP);

`ifdef GAP_DIFF_LIMIT_EN
  logic [Y_W-1:0] r_lastGapY;
  logic [Y_W-1:0] w_low;
  logic [Y_W-1:0] w_high;

  always_comb begin
    w_low  = (r_lastGapY > Y_W'(MAX_DELTA)) ? (r_lastGapY - Y_W'(MAX_DELTA)) : '0;
    w_high = r_lastGapY + Y_W'(MAX_DELTA);
    w_gapY = w_rawGap;
    if (w_rawGap < w_low) begin
      w_gapY = w_low;
    end else if (w_rawGap > w_high) begin
      w_gapY = w_high;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_game_clear) begin
      r_lastGapY <= Y_W'(GAP_MIN_Y);
    end else if (w_doSpawn) begin
      r_lastGapY <= w_gapY;
    end
  end
`else
  assign w_gapY = w_rawGap;
`endif

  always_comb begin
    w_anyFree = 1'b0;
    w_freeIdx = '0;
    for (int i = PIPE_SLOTS - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_anyFree = 1'b1;
        w_freeIdx = IDX_W'(i);
      end
    end
  end

  for (genvar g = 0; g < PIPE_SLOTS; g++) begin : g_slot
    pipe_slot #(
      .SPEED(SPEED)
    ) u_slot (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_scroll     (w_advance),
      .i_load       (w_doSpawn && (w_freeIdx == IDX_W'(g))),
      .i_clear      (i_game_clear),
      .i_load_gap_y (w_gapY),
      .o_valid      (o_pipe_valid[g]),
      .o_x          (o_pipe_x[g*X_W +: X_W]),
      .o_gap_y      (o_pipe_gap_y[g*Y_W +: Y_W]),
      .o_retire     (w_retire[g]),
      .o_crossed    (w_crossed[g])
    );
    assign w_free[g] = !o_pipe_valid[g] || w_retire[g];
  end

  always_comb begin
    w_nextState = r_state;
    if (i_game_clear) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_game_run)  w_nextState = RUN;
        RUN:     if (!i_game_run) w_nextState = FREEZE;
        FREEZE:  if (i_game_run)  w_nextState = RUN;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // A failed spawn leaves the counter at zero so the next tick retries.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_spawnCnt   <= '0;
      r_spawnPulse <= 1'b0;
      r_scorePulse <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_spawnPulse <= w_doSpawn;
      r_scorePulse <= w_advance && (|w_crossed);
      if (i_game_clear || ((r_state == IDLE) && i_game_run)) begin
        r_spawnCnt <= '0;
      end else if (w_advance) begin
        if (r_spawnCnt != '0) begin
          r_spawnCnt <= r_spawnCnt - 1'b1;
        end else if (w_anyFree) begin
          r_spawnCnt <= CNT_W'(SPAWN_FRAMES - 1);
        end
      end
    end
  end

  assign o_spawn_pulse = r_spawnPulse;
  assign o_score_pulse = r_scorePulse;

endmodule

// File: tb/tb_pipe_gap_generator.sv
// Directed bench for pipe_gap_generator: a vector table for the basic flow,
// then hand sequences for long scrolling, retry/refill, freeze and clear.
module tb_pipe_gap_generator;
  import pipe_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                frameTick;
  logic                gameRun;
  logic                gameClear;
  logic [4:0]          rndData;
  logic [3:0]          pipeValid;
  logic [4*X_W-1:0]    pipeX;
  logic [4*Y_W-1:0]    pipeGapY;
  logic                spawnPulse;
  logic                scorePulse;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       tick;
    logic       run;
    logic       clear;
    logic [4:0] rnd;
    logic [3:0] expValid;
    int         expX0;
    int         expGap0;
    logic       expSpawn;
    logic       expScore;
    logic       chkPos;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  pipe_gap_generator dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_tick (frameTick),
    .i_game_run   (gameRun),
    .i_game_clear (gameClear),
    .i_rnd_data   (rndData),
    .o_pipe_valid (pipeValid),
    .o_pipe_x     (pipeX),
    .o_pipe_gap_y (pipeGapY),
    .o_spawn_pulse(spawnPulse),
    .o_score_pulse(scorePulse)
  );

  function automatic int slotX(input int i);
    return int'(pipeX[i*X_W +: X_W]);
  endfunction

  function automatic int slotGap(input int i);
    return int'(pipeGapY[i*Y_W +: Y_W]);
  endfunction

  task automatic applyStimulus(input logic tick, input logic run, input logic clear,
                               input logic [4:0] rnd);
    frameTick = tick;
    gameRun   = run;
    gameClear = clear;
    rndData   = rnd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  initial begin
    int gapFirst;
    int expSpawn;
    int expScore;

`ifdef GAP_DIFF_LIMIT_EN
    gapFirst = 144;
`else
    gapFirst = 328;
`endif

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'd0, 4'b0000,   0,   0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'd0, 4'b0000,   0,   0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 5'd5, 4'b0001, 640, 120, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 5'd0, 4'b0001, 640, 120, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'd9, 4'b0001, 638, 120, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'd0, 4'b0001, 638, 120, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'd0, 4'b0001, 638, 120, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'd0, 4'b0001, 638, 120, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 5'd0, 4'b0001, 636, 120, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 5'd0, 4'b0000,   0,   0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 5'd0, 4'b0000,   0,   0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 5'd0, 4'b0001, 640,  80, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("reset_valid", int'(pipeValid), 0);
    checkOutput("reset_x", int'(pipeX), 0);
    checkOutput("reset_gap", int'(pipeGapY), 0);
    checkOutput("reset_spawn", int'(spawnPulse), 0);
    checkOutput("reset_score", int'(scorePulse), 0);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].tick, vecs[v].run, vecs[v].clear, vecs[v].rnd);
      checkOutput($sformatf("vec%0d_valid", v), int'(pipeValid), int'(vecs[v].expValid));
      checkOutput($sformatf("vec%0d_spawn", v), int'(spawnPulse), int'(vecs[v].expSpawn));
      checkOutput($sformatf("vec%0d_score", v), int'(scorePulse), int'(vecs[v].expScore));
      if (vecs[v].chkPos) begin
        checkOutput($sformatf("vec%0d_x0", v), slotX(0), vecs[v].expX0);
        checkOutput($sformatf("vec%0d_gap0", v), slotGap(0), vecs[v].expGap0);
      end
    end

    // Long run: spawn with rnd 31, fill all slots, retry when full, refill slot 0.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd0);
    checkOutput("clear_valid", int'(pipeValid), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd31);
    checkOutput("rnd31_spawn", int'(spawnPulse), 1);
    checkOutput("rnd31_x0", slotX(0), 640);
    checkOutput("rnd31_gap0", slotGap(0), gapFirst);
    for (int n = 2; n <= 322; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd3);
      expSpawn = (n == 81 || n == 161 || n == 241 || n == 322) ? 1 : 0;
      expScore = (n == 242 || n == 322) ? 1 : 0;
      checkOutput($sformatf("run_n%0d_spawn", n), int'(spawnPulse), expSpawn);
      checkOutput($sformatf("run_n%0d_score", n), int'(scorePulse), expScore);
      if (n == 241) begin
        checkOutput("n241_x0", slotX(0), 160);
        checkOutput("n241_valid", int'(pipeValid), 15);
        checkOutput("n241_gap3", slotGap(3), 104);
      end
      if (n == 321) begin
        checkOutput("n321_x0", slotX(0), 0);
        checkOutput("n321_valid", int'(pipeValid), 15);
      end
      if (n == 322) begin
        checkOutput("n322_x0", slotX(0), 640);
        checkOutput("n322_gap0", slotGap(0), 104);
        checkOutput("n322_valid", int'(pipeValid), 15);
        checkOutput("n322_x1", slotX(1), 158);
        checkOutput("n322_x3", slotX(3), 478);
      end
    end

    // Freeze with ticks present: nothing moves, then resume from held values.
    for (int k = 0; k < 50; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd7);
      checkOutput($sformatf("freeze%0d_spawn", k), int'(spawnPulse), 0);
      checkOutput($sformatf("freeze%0d_score", k), int'(scorePulse), 0);
    end
    checkOutput("freeze_x0", slotX(0), 640);
    checkOutput("freeze_x1", slotX(1), 158);
    checkOutput("freeze_gap0", slotGap(0), 104);
    checkOutput("freeze_valid", int'(pipeValid), 15);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
    checkOutput("resume_x0", slotX(0), 638);
    checkOutput("resume_x1", slotX(1), 156);
    checkOutput("resume_spawn", int'(spawnPulse), 0);

    // Clear together with a tick, then ticks in IDLE do nothing.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd0);
    checkOutput("midclear_valid", int'(pipeValid), 0);
    checkOutput("midclear_spawn", int'(spawnPulse), 0);
    checkOutput("midclear_score", int'(scorePulse), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    checkOutput("idle_valid", int'(pipeValid), 0);
    checkOutput("idle_spawn", int'(spawnPulse), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
